vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 34 +++
 rtl/vga_sync_delay.sv | 41 ++++
 rtl/vga_timing_gen.sv | 146 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared timing constants and types for the VGA pixel-timing generator.
// Defaults describe 640x480 at 60 Hz with a 25 MHz pixel clock.
package vga_timing_pkg;

    // Horizontal timing, in pixel clocks.
    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FP_DEF      = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BP_DEF      = 48;

    // Vertical timing, in lines.
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FP_DEF      = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BP_DEF      = 33;

    // Largest count a 10-bit coordinate can span.
    localparam int COORD_SPAN    = 1024;

    // Maximum number of delay stages on the sync outputs.
    localparam int SYNC_DLY_MAX  = 4;

    typedef logic [9:0] coord_t;

    // Total length of a line or frame from its four timing segments.
    function automatic int line_total(input int visible, input int fp,
                                      input int sync, input int bp);
        return visible + fp + sync + bp;
    endfunction

    localparam int H_TOTAL_DEF = line_total(H_VISIBLE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
    localparam int V_TOTAL_DEF = line_total(V_VISIBLE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

endpackage

// File: rtl/vga_sync_delay.sv
// Fixed-depth shift register that delays the raw sync levels so they line
// up with the drawing stage's registered RGB. Depth 0 is a plain wire.
module vga_sync_delay #(
    parameter int               WIDTH   = 2,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    if (DEPTH == 0) begin : g_bypass
        // Clock and reset have no load when there are no stages.
        logic unused_clk_rst;
        assign unused_clk_rst = clk_i ^ rst_n_i;
        assign data_o         = data_i;
    end else begin : g_stages
        logic [WIDTH-1:0] stage_q [DEPTH];

        // Shift the sync levels one stage per pixel clock.
        // NOTE: every stage is reset, not just the first, so a reset flushes
        // any partial sync pulse already in flight.
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= RST_VAL;
                end
            end else begin
                stage_q[0] <= data_i;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign data_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA pixel-timing generator. Produces the pixel coordinates,
// the display-enable flag, line/frame/vblank strobes and a frame counter,
// all registered and coincident with DrawX/DrawY, plus HS/VS delayed by
// SYNC_DLY clocks to match the downstream RGB register.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_VISIBLE   = H_VISIBLE_DEF,
    parameter int   H_FP        = H_FP_DEF,
    parameter int   H_SYNC      = H_SYNC_DEF,
    parameter int   H_BP        = H_BP_DEF,
    parameter int   V_VISIBLE   = V_VISIBLE_DEF,
    parameter int   V_FP        = V_FP_DEF,
    parameter int   V_SYNC      = V_SYNC_DEF,
    parameter int   V_BP        = V_BP_DEF,
    parameter logic SYNC_ACTIVE = 1'b0,
    parameter int   SYNC_DLY    = 1
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output coord_t     DrawX,
    output coord_t     DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       line_start,
    output logic       frame_start,
    output logic       vblank_start,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = line_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = line_total(V_VISIBLE, V_FP, V_SYNC, V_BP);

    if (H_TOTAL > COORD_SPAN) begin : g_err_h_total
        $error("vga_timing_gen: H_TOTAL %0d exceeds %0d", H_TOTAL, COORD_SPAN);
    end
    if (V_TOTAL > COORD_SPAN) begin : g_err_v_total
        $error("vga_timing_gen: V_TOTAL %0d exceeds %0d", V_TOTAL, COORD_SPAN);
    end
    if (SYNC_DLY < 0 || SYNC_DLY > SYNC_DLY_MAX) begin : g_err_sync_dly
        $error("vga_timing_gen: SYNC_DLY %0d outside 0..%0d", SYNC_DLY, SYNC_DLY_MAX);
    end

    // Last count of each axis; the counters wrap to zero from here.
    localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);
    localparam coord_t V_VIS_Y = coord_t'(V_VISIBLE);

    // Region bounds are one bit wider than a coordinate so a window ending
    // exactly at 1024 still compares correctly.
    localparam logic [10:0] H_VIS_END = 11'(H_VISIBLE);
    localparam logic [10:0] HS_BEGIN  = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] HS_END    = 11'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [10:0] V_VIS_END = 11'(V_VISIBLE);
    localparam logic [10:0] VS_BEGIN  = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0] VS_END    = 11'(V_VISIBLE + V_FP + V_SYNC);

    coord_t     x_q, x_d;
    coord_t     y_q, y_d;
    logic       blank_q, blank_d;
    logic       line_start_q, line_start_d;
    logic       frame_start_q, frame_start_d;
    logic       vblank_start_q, vblank_start_d;
    logic       hs_raw_q, hs_raw_d;
    logic       vs_raw_q, vs_raw_d;
    logic [7:0] frame_count_q, frame_count_d;
    logic [1:0] sync_dly;

    // Advance the pixel position: column every clock, row on column wrap.
    // NOTE: each output is given a value before any branch, so no path
    // through the block can leave a latch behind.
    always_comb begin
        x_d = x_q + coord_t'(1);
        y_d = y_q;
        if (x_q == H_LAST) begin
            x_d = '0;
            y_d = (y_q == V_LAST) ? '0 : y_q + coord_t'(1);
        end
    end

    // Decode the upcoming position so the registered flags land on the
    // same edge as the coordinates they describe.
    always_comb begin
        blank_d        = ({1'b0, x_d} < H_VIS_END) && ({1'b0, y_d} < V_VIS_END);
        line_start_d   = (x_d == '0);
        frame_start_d  = line_start_d && (y_d == '0);
        vblank_start_d = line_start_d && (y_d == V_VIS_Y);
        hs_raw_d       = (({1'b0, x_d} >= HS_BEGIN) && ({1'b0, x_d} < HS_END))
                         ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        // The row only moves on the column wrap, so this is line-granular.
        vs_raw_d       = (({1'b0, y_d} >= VS_BEGIN) && ({1'b0, y_d} < VS_END))
                         ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        frame_count_d  = frame_count_q + 8'(frame_start_d);
    end

    // Timing state register; reset parks the counters one clock before the
    // first pixel so the first edge after release starts a frame.
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q            <= H_LAST;
            y_q            <= V_LAST;
            blank_q        <= 1'b0;
            line_start_q   <= 1'b0;
            frame_start_q  <= 1'b0;
            vblank_start_q <= 1'b0;
            hs_raw_q       <= ~SYNC_ACTIVE;
            vs_raw_q       <= ~SYNC_ACTIVE;
            frame_count_q  <= '0;
        end else begin
            x_q            <= x_d;
            y_q            <= y_d;
            blank_q        <= blank_d;
            line_start_q   <= line_start_d;
            frame_start_q  <= frame_start_d;
            vblank_start_q <= vblank_start_d;
            hs_raw_q       <= hs_raw_d;
            vs_raw_q       <= vs_raw_d;
            frame_count_q  <= frame_count_d;
        end
    end

    vga_sync_delay #(
        .WIDTH   (2),
        .DEPTH   (SYNC_DLY),
        .RST_VAL ({2{~SYNC_ACTIVE}})
    ) u_sync_delay (
        .clk_i   (vga_clk),
        .rst_n_i (reset_n),
        .data_i  ({hs_raw_q, vs_raw_q}),
        .data_o  (sync_dly)
    );

    assign DrawX        = x_q;
    assign DrawY        = y_q;
    assign blank        = blank_q;
    assign line_start   = line_start_q;
    assign frame_start  = frame_start_q;
    assign vblank_start = vblank_start_q;
    assign frame_count  = frame_count_q;
    assign hs           = sync_dly[1];
    assign vs           = sync_dly[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. Three instances share one clock and reset:
//   dut_s : tiny 15x10 timing, SYNC_DLY=1, active-low sync (fast frames)
//   dut_d : default 640x480 timing and sync settings
//   dut_z : default timing, SYNC_DLY=0, active-high sync
// A model computes every output from the number of clocks since reset
// release; a compare process checks all three each cycle, and directed
// checks pin key points with hand-derived literals.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       blank;
        logic       hs;
        logic       vs;
        logic       ls;
        logic       fs;
        logic       vbs;
        logic [7:0] fc;
    } obs_t;

    logic vga_clk = 1'b0;
    logic reset_n = 1'b0;
    int   n       = 0;  // clocks since reset release; 0 while in reset
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [9:0] s_x, s_y, d_x, d_y, z_x, z_y;
    logic       s_blank, s_hs, s_vs, s_ls, s_fs, s_vbs;
    logic       d_blank, d_hs, d_vs, d_ls, d_fs, d_vbs;
    logic       z_blank, z_hs, z_vs, z_ls, z_fs, z_vbs;
    logic [7:0] s_fc, d_fc, z_fc;
    obs_t       s_obs, d_obs, z_obs;

    assign s_obs = {s_x, s_y, s_blank, s_hs, s_vs, s_ls, s_fs, s_vbs, s_fc};
    assign d_obs = {d_x, d_y, d_blank, d_hs, d_vs, d_ls, d_fs, d_vbs, d_fc};
    assign z_obs = {z_x, z_y, z_blank, z_hs, z_vs, z_ls, z_fs, z_vbs, z_fc};

    always #20 vga_clk = ~vga_clk;

    always @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) n <= 0;
        else          n <= n + 1;
    end

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_ACTIVE(1'b0), .SYNC_DLY(1)
    ) dut_s (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(s_x), .DrawY(s_y),
        .blank(s_blank), .hs(s_hs), .vs(s_vs), .line_start(s_ls),
        .frame_start(s_fs), .vblank_start(s_vbs), .frame_count(s_fc)
    );

    vga_timing_gen dut_d (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(d_x), .DrawY(d_y),
        .blank(d_blank), .hs(d_hs), .vs(d_vs), .line_start(d_ls),
        .frame_start(d_fs), .vblank_start(d_vbs), .frame_count(d_fc)
    );

    vga_timing_gen #(
        .SYNC_ACTIVE(1'b1), .SYNC_DLY(0)
    ) dut_z (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(z_x), .DrawY(z_y),
        .blank(z_blank), .hs(z_hs), .vs(z_vs), .line_start(z_ls),
        .frame_start(z_fs), .vblank_start(z_vbs), .frame_count(z_fc)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t, n=%0d)", name, act, exp, $time, n);
        end
    endtask

    // Expected outputs after n clocks of free running, from the timing rules:
    // position n-1 in the frame raster, sync from the position dly clocks ago.
    function automatic obs_t model(input int cyc, input int hv, input int hf, input int hsw,
                                   input int hb, input int vv, input int vf, input int vsw,
                                   input int vb, input int dly, input logic act);
        obs_t e;
        int   ht   = hv + hf + hsw + hb;
        int   vt   = vv + vf + vsw + vb;
        int   fr   = ht * vt;
        int   pos, x, y, m, px, py;
        e    = '0;
        e.hs = ~act;
        e.vs = ~act;
        if (cyc == 0) begin
            e.x = 10'(ht - 1);
            e.y = 10'(vt - 1);
        end else begin
            pos     = (cyc - 1) % fr;
            x       = pos % ht;
            y       = pos / ht;
            e.x     = 10'(x);
            e.y     = 10'(y);
            e.blank = (x < hv) && (y < vv);
            e.ls    = (x == 0);
            e.fs    = (pos == 0);
            e.vbs   = (x == 0) && (y == vv);
            e.fc    = 8'((((cyc - 1) / fr) + 1) % 256);
            m = cyc - dly;
            if (m >= 1) begin
                px = ((m - 1) % fr) % ht;
                py = ((m - 1) % fr) / ht;
                if (px >= hv + hf && px < hv + hf + hsw) e.hs = act;
                if (py >= vv + vf && py < vv + vf + vsw) e.vs = act;
            end
        end
        return e;
    endfunction

    // Every cycle, away from the active edge, compare all three instances.
    always @(negedge vga_clk) begin
        check("model_s", s_obs, model(n, 8, 2, 3, 2, 6, 1, 2, 1, 1, 1'b0));
        check("model_d", d_obs, model(n, 640, 16, 96, 48, 480, 10, 2, 33, 1, 1'b0));
        check("model_z", z_obs, model(n, 640, 16, 96, 48, 480, 10, 2, 33, 0, 1'b1));
    end

    task automatic wait_n(input int target);
        int guard = 0;
        while (n != target && guard < 60000) begin
            @(negedge vga_clk);
            guard++;
        end
        check("wait_n_reached", 64'(n), 64'(target));
    endtask

    initial begin
        int hs_low, ls_cnt, ls_first, ls_second, first_x, z_bad, z_high;
        int vs_low, vs_fx, vs_fy, vbs_cnt, vbs_y, fs_cnt, blank_cnt;

        // Reset state, clock already running.
        #30;
        check("rst_d_x", d_x, 799);
        check("rst_d_y", d_y, 524);
        check("rst_d_hs", d_hs, 1);
        check("rst_d_vs", d_vs, 1);
        check("rst_d_blank", d_blank, 0);
        check("rst_d_fc", d_fc, 0);
        check("rst_d_fs", d_fs, 0);
        check("rst_z_hs", z_hs, 0);
        check("rst_s_x", s_x, 14);
        check("rst_s_y", s_y, 9);

        @(negedge vga_clk);
        @(negedge vga_clk);
        reset_n = 1'b1;

        // First edge after release starts a frame.
        @(negedge vga_clk);
        check("first_x", d_x, 0);
        check("first_y", d_y, 0);
        check("first_blank", d_blank, 1);
        check("first_fs", d_fs, 1);
        check("first_ls", d_ls, 1);
        check("first_fc", d_fc, 1);
        check("first_hs", d_hs, 1);
        check("first_vs", d_vs, 1);
        check("first_z_hs", z_hs, 0);

        // Visible region ends between columns 639 and 640.
        wait_n(640);
        check("col639_x", d_x, 639);
        check("col639_blank", d_blank, 1);
        wait_n(641);
        check("col640_x", d_x, 640);
        check("col640_blank", d_blank, 0);

        // Two line periods of sync and line strobes.
        hs_low = 0; ls_cnt = 0; ls_first = 0; ls_second = 0;
        first_x = -1; z_bad = 0; z_high = 0;
        for (int i = 0; i < 1000; i++) begin
            if (!d_hs) begin
                if (first_x < 0) first_x = int'(d_x);
                hs_low++;
            end
            if (d_ls) begin
                ls_cnt++;
                if (ls_cnt == 1) ls_first = n;
                else             ls_second = n;
            end
            if (z_hs !== ((z_x >= 656) && (z_x <= 751))) z_bad++;
            if (z_hs) z_high++;
            @(negedge vga_clk);
        end
        check("hs_first_low_x", 64'(first_x), 657);
        check("hs_low_cycles", 64'(hs_low), 192);
        check("ls_count", 64'(ls_cnt), 2);
        check("ls_period", 64'(ls_second - ls_first), 800);
        check("z_hs_window_mismatch", 64'(z_bad), 0);
        check("z_hs_high_cycles", 64'(z_high), 192);

        // One full frame of the small instance, starting at a frame strobe.
        wait_n(1651);
        check("s_frame12_fs", s_fs, 1);
        check("s_frame12_fc", s_fc, 12);
        hs_low = 0; vs_low = 0; vs_fx = -1; vs_fy = -1; vbs_cnt = 0;
        vbs_y = -1; fs_cnt = 0; ls_cnt = 0; blank_cnt = 0;
        for (int i = 0; i < 150; i++) begin
            if (!s_hs) hs_low++;
            if (!s_vs) begin
                if (vs_fx < 0) begin
                    vs_fx = int'(s_x);
                    vs_fy = int'(s_y);
                end
                vs_low++;
            end
            if (s_vbs) begin
                vbs_cnt++;
                vbs_y = int'(s_y);
            end
            if (s_fs) fs_cnt++;
            if (s_ls) ls_cnt++;
            if (s_blank) blank_cnt++;
            @(negedge vga_clk);
        end
        check("s_hs_low", 64'(hs_low), 30);
        check("s_vs_low", 64'(vs_low), 30);
        check("s_vs_first_x", 64'(vs_fx), 1);
        check("s_vs_first_y", 64'(vs_fy), 7);
        check("s_vbs_count", 64'(vbs_cnt), 1);
        check("s_vbs_row", 64'(vbs_y), 6);
        check("s_fs_count", 64'(fs_cnt), 1);
        check("s_ls_count", 64'(ls_cnt), 10);
        check("s_blank_count", 64'(blank_cnt), 48);

        // Frame counter wrap on the 256th frame strobe.
        wait_n(38250);
        check("s_fc_255", s_fc, 255);
        check("s_fs_before_wrap", s_fs, 0);
        wait_n(38251);
        check("s_fc_wrap", s_fc, 0);
        check("s_fs_wrap", s_fs, 1);

        // Inside both sync pulses of the small instance, then reset mid-cycle.
        wait_n(38517);
        check("mid_s_x", s_x, 11);
        check("mid_s_y", s_y, 7);
        check("mid_s_hs", s_hs, 0);
        check("mid_s_vs", s_vs, 0);
        #10;
        reset_n = 1'b0;
        #1;
        check("async_s_x", s_x, 14);
        check("async_s_y", s_y, 9);
        check("async_s_hs", s_hs, 1);
        check("async_s_vs", s_vs, 1);
        check("async_s_fc", s_fc, 0);
        check("async_s_blank", s_blank, 0);
        check("async_d_x", d_x, 799);
        check("async_d_y", d_y, 524);
        check("async_d_hs", d_hs, 1);
        check("async_z_hs", z_hs, 0);
        check("async_z_vs", z_vs, 0);

        repeat (3) @(negedge vga_clk);
        check("held_s_hs", s_hs, 1);
        reset_n = 1'b1;
        @(negedge vga_clk);
        check("rerun_s_x", s_x, 0);
        check("rerun_s_y", s_y, 0);
        check("rerun_s_fs", s_fs, 1);
        check("rerun_s_fc", s_fc, 1);
        check("rerun_s_hs", s_hs, 1);
        check("rerun_d_fs", d_fs, 1);
        repeat (40) @(negedge vga_clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
